// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding,
// run-mode codes and small mode-decode helpers.
package cnt_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic [1:0] MODE_ONESHOT     = 2'b00;
  localparam logic [1:0] MODE_LOOP        = 2'b01;
  localparam logic [1:0] MODE_PINGPONG    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT_ALT = 2'b11;

  // Code 11 behaves exactly like one-shot.
  function automatic logic is_oneshot(input logic [1:0] mode);
    return (mode == MODE_ONESHOT) || (mode == MODE_ONESHOT_ALT);
  endfunction

  function automatic logic is_loop(input logic [1:0] mode);
    return mode == MODE_LOOP;
  endfunction

  function automatic logic is_pingpong(input logic [1:0] mode);
    return mode == MODE_PINGPONG;
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl_tick_div.sv
// tick_div: programmable step prescaler.
// Counts 0..i_div while enabled; o_tick is high for the one cycle the count
// equals i_div, after which the count wraps to 0. i_div = 0 ticks every cycle.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   i_clr        synchronous clear of the count (priority over i_en)
//   i_en         count enable; o_tick is forced low while disabled
//   i_div        divide value (period = i_div + 1 cycles)
//   o_tick       one-cycle tick
module tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequencer for a 4-bit loadable up/down counter.
// Latches a run programme on START and drives the counter's load/clear/
// enable/direction pins to produce one-shot, looping or ping-pong runs at a
// prescaled step rate.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   i_start, i_stop     launch (sampled in IDLE) / abort
//   i_mode, i_dir       run mode, initial direction (1 = up)
//   i_start_val/end_val pass start and target values
//   i_presc             step period = i_presc + 1 cycles
//   i_cnt_q             counter output (registered)
//   o_cnt_pe/d/clr/en/flag  counter control pins (combinational decode)
//   o_busy, o_done      LOAD/RUN indication, one-cycle completion pulse
//   o_laps              completed passes in the current run (saturating)
//
// state   | meaning
// IDLE    | waiting for START; no strobes
// LOAD    | one cycle: load START_VAL into counter, clear prescaler
// RUN     | stepping on prescaler ticks toward the current target
// DONE    | one cycle: one-shot completion pulse, then back to IDLE
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  input  logic [3:0]       i_start_val,
  input  logic [3:0]       i_end_val,
  input  logic [DIV_W-1:0] i_presc,
  input  logic [3:0]       i_cnt_q,
  output logic             o_cnt_pe,
  output logic [3:0]       o_cnt_d,
  output logic             o_cnt_clr,
  output logic             o_cnt_en,
  output logic             o_cnt_flag,
  output logic             o_busy,
  output logic             o_done,
  output logic [LAP_W-1:0] o_laps
);

  state_t r_state, w_state_nxt;

  logic [1:0]       r_mode;
  logic [3:0]       r_start_val;
  logic [3:0]       r_end_val;
  logic [DIV_W-1:0] r_presc;
  logic             r_dir_cur;   // direction of the leg in progress
  logic             r_ret_leg;   // ping-pong: 1 while heading back to START_VAL
  logic [LAP_W-1:0] r_laps;

  logic       w_tick;
  logic       w_launch;
  logic       w_abort;
  logic [3:0] w_target;
  logic       w_at_target;
  logic       w_pass_done;

  tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (r_state == ST_LOAD),
    .i_en   (r_state == ST_RUN),
    .i_div  (r_presc),
    .o_tick (w_tick)
  );

  assign w_launch    = (r_state == ST_IDLE) && i_start && !i_stop;
  assign w_abort     = (r_state != ST_IDLE) && i_stop;
  assign w_target    = r_ret_leg ? r_start_val : r_end_val;
  assign w_at_target = (i_cnt_q == w_target);
  assign w_pass_done = (r_state == ST_RUN) && !i_stop && w_tick && w_at_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = i_stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (i_stop)                                w_state_nxt = ST_IDLE;
        else if (w_pass_done && is_oneshot(r_mode)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter pins are decoded from state, tick and Q; STOP masks EN/PE so the
  // three strobes never overlap.
  always_comb begin
    o_cnt_pe   = 1'b0;
    o_cnt_en   = 1'b0;
    o_cnt_clr  = w_abort;
    o_cnt_d    = r_start_val;
    o_cnt_flag = r_dir_cur;
    o_busy     = (r_state == ST_LOAD) || (r_state == ST_RUN);
    o_done     = (r_state == ST_DONE);
    if (!w_abort) begin
      if (r_state == ST_LOAD) begin
        o_cnt_pe = 1'b1;
      end else if (r_state == ST_RUN && w_tick) begin
        if (!w_at_target)        o_cnt_en = 1'b1;
        else if (is_loop(r_mode)) o_cnt_pe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= '0;
      r_start_val <= '0;
      r_end_val   <= '0;
      r_presc     <= '0;
      r_dir_cur   <= 1'b0;
      r_ret_leg   <= 1'b0;
      r_laps      <= '0;
    end else if (w_launch) begin
      r_mode      <= i_mode;
      r_start_val <= i_start_val;
      r_end_val   <= i_end_val;
      r_presc     <= i_presc;
      r_dir_cur   <= i_dir;
      r_ret_leg   <= 1'b0;
      r_laps      <= '0;
    end else if (w_pass_done) begin
      if (r_laps != '1) r_laps <= r_laps + LAP_W'(1);
      if (is_pingpong(r_mode)) begin
        r_dir_cur <= ~r_dir_cur;
        r_ret_leg <= ~r_ret_leg;
      end
    end
  end

  assign o_laps = r_laps;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
module tb_cnt_seq_ctrl;
  localparam int DIV_W = 16;
  localparam int LAP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             dir = 1'b0;
  logic [3:0]       sval = 4'h0;
  logic [3:0]       eval = 4'h0;
  logic [DIV_W-1:0] presc = '0;
  logic [3:0]       q;
  logic             pe, clr, en, flag, busy, done;
  logic [3:0]       d;
  logic [LAP_W-1:0] laps;

  int checks = 0;
  int errors = 0;

  logic [3:0] pp_q [0:21];

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.DIV_W(DIV_W), .LAP_W(LAP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_mode      (mode),
    .i_dir       (dir),
    .i_start_val (sval),
    .i_end_val   (eval),
    .i_presc     (presc),
    .i_cnt_q     (q),
    .o_cnt_pe    (pe),
    .o_cnt_d     (d),
    .o_cnt_clr   (clr),
    .o_cnt_en    (en),
    .o_cnt_flag  (flag),
    .o_busy      (busy),
    .o_done      (done),
    .o_laps      (laps)
  );

  // Closed-loop 4-bit loadable up/down counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 4'h0;
    else if (clr) q <= 4'h0;
    else if (pe)  q <= d;
    else if (en)  q <= flag ? q + 4'h1 : q - 4'h1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("strobe_excl", 32'($onehot0({en, pe, clr})), 32'd1);
  endtask

  // Launch a run; returns one cycle into RUN (k = 0).
  task automatic launch(input logic [1:0] m, input logic dr, input logic [3:0] sv,
                        input logic [3:0] ev, input logic [DIV_W-1:0] ps);
    mode = m; dir = dr; sval = sv; eval = ev; presc = ps; start = 1'b1;
    step();
    start = 1'b0;
    // Inputs scrambled after launch must be ignored.
    mode = ~m; dir = ~dr; sval = ~sv; eval = ~ev; presc = ps + 16'd5;
    chk("load_pe", 32'(pe), 32'd1);
    chk("load_d", 32'(d), 32'(sv));
    chk("load_busy", 32'(busy), 32'd1);
    step();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pp_q = '{4'h2, 4'h2, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4,
             4'h4, 4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h3};

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_laps", 32'(laps), 32'd0);
    chk("rst_strobes", 32'({pe, en, clr, flag}), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // 1. One-shot up 3 -> 7, PRESC=0
    launch(2'b00, 1'b1, 4'h3, 4'h7, 16'd0);
    chk("t1_q0", 32'(q), 32'h3);
    chk("t1_en0", 32'(en), 32'd1);
    chk("t1_flag", 32'(flag), 32'd1);
    step(); chk("t1_q1", 32'(q), 32'h4);
    step(); chk("t1_q2", 32'(q), 32'h5);
    step(); chk("t1_q3", 32'(q), 32'h6);
    step(); chk("t1_q4", 32'(q), 32'h7);
    chk("t1_en_end", 32'(en), 32'd0);
    chk("t1_done_early", 32'(done), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_laps", 32'(laps), 32'd1);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_q_hold", 32'(q), 32'h7);

    // 2. One-shot down across wrap 1 -> E
    launch(2'b00, 1'b0, 4'h1, 4'hE, 16'd0);
    chk("t2_q0", 32'(q), 32'h1);
    chk("t2_flag", 32'(flag), 32'd0);
    step(); chk("t2_q1", 32'(q), 32'h0);
    step(); chk("t2_q2", 32'(q), 32'hF);
    step(); chk("t2_q3", 32'(q), 32'hE);
    step();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_laps", 32'(laps), 32'd1);
    chk("t2_q_hold", 32'(q), 32'hE);
    step();

    // 3. Ping-pong 2 <-> 4, PRESC=2
    launch(2'b10, 1'b1, 4'h2, 4'h4, 16'd2);
    for (int k = 0; k < 22; k++) begin
      if (k > 0) step();
      chk($sformatf("t3_q_k%0d", k), 32'(q), 32'(pp_q[k]));
      chk($sformatf("t3_laps_k%0d", k), 32'(laps), (k < 9) ? 32'd0 : (k < 18) ? 32'd1 : 32'd2);
      if (k == 1)  chk("t3_en_k1", 32'(en), 32'd0);
      if (k == 2)  chk("t3_en_k2", 32'({en, flag}), 32'b11);
      if (k == 11) chk("t3_en_k11", 32'({en, flag}), 32'b10);
      chk($sformatf("t3_busy_k%0d", k), 32'(busy), 32'd1);
    end
    stop = 1'b1;
    #1;
    chk("t3_stop_clr", 32'({clr, en, pe}), 32'b100);
    step();
    stop = 1'b0;
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk("t3_stop_q", 32'(q), 32'h0);
    chk("t3_stop_laps", 32'(laps), 32'd2);

    // 4. Loop 0 -> 2
    launch(2'b01, 1'b1, 4'h0, 4'h2, 16'd0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      chk($sformatf("t4_q_k%0d", k), 32'(q), 32'(k % 3));
      chk($sformatf("t4_laps_k%0d", k), 32'(laps), 32'(k / 3));
      if (k == 2) chk("t4_reload", 32'({pe, en, d}), 32'b10_0000);
    end
    stop = 1'b1; step(); stop = 1'b0;

    // LAPS saturation: loop with START_VAL == END_VAL completes a pass per tick
    launch(2'b01, 1'b1, 4'h5, 4'h5, 16'd0);
    chk("sat_pe_k0", 32'({pe, en}), 32'b10);
    for (int k = 1; k <= 260; k++) begin
      step();
      if (k == 100) chk("sat_laps_100", 32'(laps), 32'd100);
    end
    chk("sat_laps", 32'(laps), 32'd255);
    chk("sat_q", 32'(q), 32'h5);
    stop = 1'b1; step(); stop = 1'b0;

    // 5. STOP mid-run at Q=5
    launch(2'b00, 1'b1, 4'h3, 4'h9, 16'd0);
    step(); step();
    chk("t5_q5", 32'(q), 32'h5);
    stop = 1'b1;
    #1;
    chk("t5_clr", 32'({clr, en, pe}), 32'b100);
    step();
    stop = 1'b0;
    chk("t5_q0", 32'(q), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    step();
    chk("t5_no_done", 32'(done), 32'd0);
    start = 1'b1; stop = 1'b1;
    step();
    chk("t5_ss_busy", 32'(busy), 32'd0);
    chk("t5_ss_pe", 32'(pe), 32'd0);
    step();
    chk("t5_ss_busy2", 32'(busy), 32'd0);
    start = 1'b0; stop = 1'b0;

    // 6. Async reset mid-RUN, then relaunch START_VAL == END_VAL = 9 with mode 11
    launch(2'b00, 1'b1, 4'h0, 4'hF, 16'd3);
    for (int k = 0; k < 4; k++) step();
    chk("t6_pre_q", 32'(q), 32'h1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_strobes", 32'({pe, en, clr, flag, done}), 32'd0);
    chk("t6_rst_laps", 32'(laps), 32'd0);
    chk("t6_rst_d", 32'(d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    launch(2'b11, 1'b1, 4'h9, 4'h9, 16'd0);
    chk("t6_q9", 32'(q), 32'h9);
    chk("t6_no_step", 32'({en, pe}), 32'd0);
    step();
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_laps", 32'(laps), 32'd1);
    chk("t6_q_hold", 32'(q), 32'h9);
    step();
    chk("t6_done_pulse", 32'(done), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
